// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the command-fetch path (cmd_*)
//   and the data path (dat_*). Round-robin arbitration on ties, one mem_en
//   strobe per access, one-cycle dv pulse back to the granted requester,
//   and a sticky err flag when the memory fails to ack within TIMEOUT
//   WAIT cycles.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   cmd_req/cmd_adr            command fetch request (level) and address
//   cmd_data/cmd_dv            fetched word (held) and completion pulse
//   dat_req/dat_we/dat_adr     data request, write select, address
//   dat_wdata                  write data
//   dat_rdata/dat_dv           read data (held) and completion pulse
//   mem_en/mem_we/mem_adr      memory strobe, write enable, address
//   mem_wdata                  memory write data
//   mem_rdata/mem_ack          memory read data and completion
//   busy                       high whenever the FSM is not idle
//   err                        sticky timeout flag, cleared by reset only
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; arbitrate requests, latch address/data of winner
// ISSUE | mem_en high for this single cycle
// WAIT  | wait for mem_ack, count cycles toward TIMEOUT
// RESP  | dv pulse to the granted port, then back to IDLE
module mem_port_arbiter #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_req,
   input  logic [ADDR_W-1:0] cmd_adr,
   output logic [DATA_W-1:0] cmd_data,
   output logic              cmd_dv,
   input  logic              dat_req,
   input  logic              dat_we,
   input  logic [ADDR_W-1:0] dat_adr,
   input  logic [DATA_W-1:0] dat_wdata,
   output logic [DATA_W-1:0] dat_rdata,
   output logic              dat_dv,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic PORT_CMD = 1'b0;
   localparam logic PORT_DAT = 1'b1;

   // Timeout fires in the TIMEOUT-th WAIT cycle, i.e. when the count of
   // WAIT cycles already spent equals TIMEOUT-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
   logic [DATA_W-1:0] dat_rdata_q, dat_rdata_d;
   logic              cmd_dv_q, cmd_dv_d;
   logic              dat_dv_q, dat_dv_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              pick;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = mem_we_q;
      mem_adr_d    = mem_adr_q;
      mem_wdata_d  = mem_wdata_q;
      cmd_data_d   = cmd_data_q;
      dat_rdata_d  = dat_rdata_q;
      cmd_dv_d     = 1'b0;
      dat_dv_d     = 1'b0;
      err_d        = err_q;
      // With a single requester, dat_req itself names the winner.
      pick         = (cmd_req && dat_req) ? ~last_grant_q : dat_req;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (cmd_req || dat_req) begin
               grant_d      = pick;
               last_grant_d = pick;
               mem_adr_d    = (pick == PORT_DAT) ? dat_adr : cmd_adr;
               mem_we_d     = (pick == PORT_DAT) && dat_we;
               mem_wdata_d  = (pick == PORT_DAT) ? dat_wdata : '0;
               mem_en_d     = 1'b1;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (mem_ack) begin
               if (!mem_we_q) begin
                  if (grant_q == PORT_DAT) dat_rdata_d = mem_rdata;
                  else                     cmd_data_d  = mem_rdata;
               end
               cmd_dv_d = (grant_q == PORT_CMD);
               dat_dv_d = (grant_q == PORT_DAT);
               state_d  = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d = 1'b1;
               if (grant_q == PORT_DAT) dat_rdata_d = '0;
               else                     cmd_data_d  = '0;
               cmd_dv_d = (grant_q == PORT_CMD);
               dat_dv_d = (grant_q == PORT_DAT);
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= PORT_DAT;
         grant_q      <= PORT_CMD;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_adr_q    <= '0;
         mem_wdata_q  <= '0;
         cmd_data_q   <= '0;
         dat_rdata_q  <= '0;
         cmd_dv_q     <= 1'b0;
         dat_dv_q     <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_adr_q    <= mem_adr_d;
         mem_wdata_q  <= mem_wdata_d;
         cmd_data_q   <= cmd_data_d;
         dat_rdata_q  <= dat_rdata_d;
         cmd_dv_q     <= cmd_dv_d;
         dat_dv_q     <= dat_dv_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign cmd_data  = cmd_data_q;
   assign cmd_dv    = cmd_dv_q;
   assign dat_rdata = dat_rdata_q;
   assign dat_dv    = dat_dv_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_adr   = mem_adr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters:
  - the command-fetch path (command word by address),
  - the data path (operand reads and result writes).
- Arbitrates round-robin, sequences the memory handshake and returns data with a one-cycle dv pulse per requester.
- Sits between the execute controller and the memory; detects hung accesses by timeout.

Parameters:
- ADDR_W, 4, address width for both requesters and the memory.
- DATA_W, 16, data word width.
- TIMEOUT, 15, max cycles in WAIT without mem_ack before abort (1..255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_req  in  1  command fetch request, level, held until cmd_dv
- cmd_adr  in  ADDR_W  command address
- cmd_data  out  DATA_W  fetched command word, valid while cmd_dv=1 and held after
- cmd_dv  out  1  one-cycle completion pulse, command port
- dat_req  in  1  data request, level, held until dat_dv
- dat_we  in  1  1=write, 0=read
- dat_adr  in  ADDR_W  data address
- dat_wdata  in  DATA_W  write data
- dat_rdata  out  DATA_W  read data, valid while dat_dv=1 and held after
- dat_dv  out  1  one-cycle completion pulse, data port
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_adr  out  ADDR_W  memory address, held from ISSUE through WAIT
- mem_wdata  out  DATA_W  memory write data, held from ISSUE through WAIT
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  1 in any state other than IDLE
- err  out  1  sticky timeout flag, cleared only by reset

Behaviour:

Reset (asynchronous):
- All outputs 0; FSM=IDLE; timeout counter 0.
- last_grant=DAT, so cmd wins the first tie.
- Reset mid-access abandons the access: no dv pulse and no retry.

FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.

IDLE:
- If only one req is high, grant it.
- If both are high, grant the port not equal to last_grant.
- On the grant edge, latch port id, adr, we and wdata (we forced to 0 for the cmd port) into mem_adr, mem_we and mem_wdata.
- Update last_grant, go to ISSUE.
- No req: stay in IDLE.

ISSUE:
- mem_en=1 for this single cycle; go to WAIT.
- mem_ack during ISSUE is ignored.

WAIT:
- mem_en=0; counter increments each cycle.
- On mem_ack:
  - read: latch mem_rdata into the granted port's data output;
  - write: dat_rdata is unchanged;
  - go to RESP.
- If the counter reaches TIMEOUT with no ack:
  - set err=1;
  - granted data output = 0;
  - go to RESP.
- If ack and timeout occur in the same cycle, ack wins and err is not set.

RESP:
- Pulse the granted port's dv for exactly one cycle, clear the counter, go to IDLE.
- Requester must drop req the cycle after dv.
- A req still high in the following IDLE cycle is a new request and is arbitrated normally.

Other rules:
- Latency: req sampled at edge 0 → mem_en in cycle 1 → earliest ack in cycle 2 → dv in cycle 3 (3 cycles minimum).
- Back-to-back accesses: at least one IDLE cycle between RESP and the next ISSUE.
- Requests arriving while busy wait; the other port's req is never dropped.
- Request inputs are sampled only in IDLE; changes to adr/wdata during an access are ignored.
- mem_ack in IDLE, ISSUE or RESP is ignored.
- cmd_dv and dat_dv are never high together.

Test Plan:
- cmd_req=1, cmd_adr=3; memory acks 1 cycle after mem_en with 0xA5C3 → mem_en cycle 1 with mem_adr=3, mem_we=0; cmd_dv pulse cycle 3 with cmd_data=0xA5C3; cmd_data holds afterwards.
- dat_req=1, dat_we=1, dat_adr=7, dat_wdata=0x0009 → mem_en=1, mem_we=1, mem_adr=7, mem_wdata=9; dat_dv one pulse; dat_rdata unchanged.
- cmd_req and dat_req both high from reset, held continuously → grants alternate cmd, dat, cmd, dat; each dv is a single pulse; no starvation over 8 accesses.
- Memory never acks; TIMEOUT=15 → after 15 WAIT cycles err=1 and dv pulses with data 0; err stays 1 through subsequent good accesses until reset.
- Ack arrives exactly on the 15th WAIT cycle → data returned, err=0.
- Assert reset during WAIT → all outputs 0 immediately (asynchronously), no dv; after release the same held req completes normally, with cmd winning the tie.
